// File: rtl/cram_async_writer.sv
// CellularRAM asynchronous write engine: drains halfwords from the input FIFO
// and issues CE#/WE#-controlled write cycles at consecutive addresses.
module cram_async_writer #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8,
    parameter int T_WP   = 6,
    parameter int T_REC  = 2
) (
    input  logic              Clock,
    input  logic              aReset_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [CNT_W-1:0]  NumHWords,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic              Aborted,
    input  logic              InFIFO_Empty,
    input  logic [DATA_W-1:0] InFIFO_Data,
    output logic              InFIFO_Rd,
    output logic [ADDR_W-1:0] CRAM_A,
    output logic [DATA_W-1:0] CRAM_DQ_Out,
    output logic              CRAM_DQ_OE,
    output logic              CRAM_CE_n,
    output logic              CRAM_WE_n,
    output logic              CRAM_OE_n,
    output logic              CRAM_ADV_n,
    output logic              CRAM_UB_n,
    output logic              CRAM_LB_n
);

    localparam int TMAX  = (T_WP > T_REC) ? T_WP : T_REC;
    localparam int TIM_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b0000001,
        S_FETCH   = 7'b0000010,
        S_LATCH   = 7'b0000100,
        S_SETUP   = 7'b0001000,
        S_WRITE   = 7'b0010000,
        S_RECOVER = 7'b0100000,
        S_DONE    = 7'b1000000
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   rem_q;
    logic [TIM_W-1:0]   timer_q;
    logic               abort_q, abort_d;
    logic               rec_exit;

    logic               busy_d, done_d, aborted_d, rd_d, oe_d, ce_n_d, we_n_d;
    logic [ADDR_W-1:0]  a_d;
    logic [DATA_W-1:0]  dq_d;

    assign rec_exit = (state_q == S_RECOVER) && (timer_q == '0);

    always_ff @(posedge Clock or negedge aReset_n) begin
        if (!aReset_n) begin
            state_q <= S_IDLE;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

    // Abort is latched in SETUP..RECOVER so the write in flight still completes.
    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    abort_d = 1'b0;
                    state_d = (NumHWords == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (Abort) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (!InFIFO_Empty) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (Abort) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (Abort) abort_d = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (Abort) abort_d = 1'b1;
                if (timer_q == '0) state_d = S_RECOVER;
            end
            S_RECOVER: begin
                if (Abort) abort_d = 1'b1;
                if (timer_q == '0)
                    state_d = (rem_q == CNT_W'(1) || abort_d) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                abort_d = 1'b0;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered pins line up with the state.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        aborted_d = (state_d == S_DONE) && abort_d;
        rd_d      = (state_q == S_FETCH) && (state_d == S_LATCH);
        ce_n_d    = !((state_d == S_SETUP) || (state_d == S_WRITE));
        we_n_d    = (state_d != S_WRITE);
        oe_d      = (state_d == S_SETUP) || (state_d == S_WRITE) ||
                    ((state_d == S_RECOVER) && (state_q == S_WRITE));
        a_d       = CRAM_A;
        dq_d      = CRAM_DQ_Out;
        if ((state_q == S_LATCH) && (state_d == S_SETUP)) begin
            a_d  = addr_q;
            dq_d = InFIFO_Data;
        end
    end

    always_ff @(posedge Clock or negedge aReset_n) begin
        if (!aReset_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            timer_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && Start) begin
                addr_q <= StartAddr;
                rem_q  <= NumHWords;
            end else if (rec_exit) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
            if (state_q == S_LATCH)
                data_q <= InFIFO_Data;
            if ((state_d == S_WRITE) && (state_q != S_WRITE))
                timer_q <= TIM_W'(T_WP - 1);
            else if ((state_d == S_RECOVER) && (state_q != S_RECOVER))
                timer_q <= TIM_W'(T_REC - 1);
            else if (timer_q != '0)
                timer_q <= timer_q - 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge aReset_n) begin
        if (!aReset_n) begin
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Aborted     <= 1'b0;
            InFIFO_Rd   <= 1'b0;
            CRAM_A      <= '0;
            CRAM_DQ_Out <= '0;
            CRAM_DQ_OE  <= 1'b0;
            CRAM_CE_n   <= 1'b1;
            CRAM_WE_n   <= 1'b1;
            CRAM_OE_n   <= 1'b1;
            CRAM_ADV_n  <= 1'b0;
            CRAM_UB_n   <= 1'b1;
            CRAM_LB_n   <= 1'b1;
        end else begin
            Busy        <= busy_d;
            Done        <= done_d;
            Aborted     <= aborted_d;
            InFIFO_Rd   <= rd_d;
            CRAM_A      <= a_d;
            CRAM_DQ_Out <= dq_d;
            CRAM_DQ_OE  <= oe_d;
            CRAM_CE_n   <= ce_n_d;
            CRAM_WE_n   <= we_n_d;
            CRAM_OE_n   <= 1'b1;
            CRAM_ADV_n  <= 1'b0;
            CRAM_UB_n   <= ce_n_d;
            CRAM_LB_n   <= ce_n_d;
        end
    end

    logic unused_data;
    assign unused_data = ^data_q;

endmodule

// File: tb/tb_cram_async_writer.sv
// Scoreboard bench for cram_async_writer: stimulus queues expected writes and
// completions, a negedge monitor checks each WE# pulse and Done pulse.
module tb_cram_async_writer;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
    localparam int T_WP   = 6;
    localparam int T_REC  = 2;

    logic              Clock = 1'b0;
    logic              aReset_n;
    logic              Start;
    logic [ADDR_W-1:0] StartAddr;
    logic [CNT_W-1:0]  NumHWords;
    logic              Abort;
    logic              Busy, Done, Aborted;
    logic              InFIFO_Empty;
    logic [DATA_W-1:0] InFIFO_Data;
    logic              InFIFO_Rd;
    logic [ADDR_W-1:0] CRAM_A;
    logic [DATA_W-1:0] CRAM_DQ_Out;
    logic              CRAM_DQ_OE, CRAM_CE_n, CRAM_WE_n, CRAM_OE_n, CRAM_ADV_n, CRAM_UB_n, CRAM_LB_n;

    cram_async_writer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .T_WP(T_WP), .T_REC(T_REC)
    ) dut (
        .Clock(Clock), .aReset_n(aReset_n), .Start(Start), .StartAddr(StartAddr),
        .NumHWords(NumHWords), .Abort(Abort), .Busy(Busy), .Done(Done), .Aborted(Aborted),
        .InFIFO_Empty(InFIFO_Empty), .InFIFO_Data(InFIFO_Data), .InFIFO_Rd(InFIFO_Rd),
        .CRAM_A(CRAM_A), .CRAM_DQ_Out(CRAM_DQ_Out), .CRAM_DQ_OE(CRAM_DQ_OE),
        .CRAM_CE_n(CRAM_CE_n), .CRAM_WE_n(CRAM_WE_n), .CRAM_OE_n(CRAM_OE_n),
        .CRAM_ADV_n(CRAM_ADV_n), .CRAM_UB_n(CRAM_UB_n), .CRAM_LB_n(CRAM_LB_n)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               exp_wr[$];
    logic              exp_done[$];
    logic [DATA_W-1:0] fifo_q[$];
    logic              force_empty;
    int                pops = 0;
    int                nchk = 0;
    int                nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // FIFO model: the word is presented while InFIFO_Rd is high and removed afterwards.
    logic pop_pend = 1'b0;
    always @(negedge Clock) begin
        if (!aReset_n) begin
            pop_pend = 1'b0;
        end else if (pop_pend) begin
            void'(fifo_q.pop_front());
            pop_pend = 1'b0;
        end
        if (aReset_n && InFIFO_Rd && fifo_q.size() > 0) begin
            InFIFO_Data = fifo_q[0];
            pop_pend    = 1'b1;
            pops++;
        end else begin
            InFIFO_Data = 16'hDEAD;
        end
        InFIFO_Empty = force_empty || (fifo_q.size() == 0);
    end

    int                wlen = 0;
    logic [ADDR_W-1:0] ca;
    logic [DATA_W-1:0] cd;
    always @(negedge Clock) begin
        if (!aReset_n) begin
            wlen = 0;
        end else begin
            chk("static_pins", {CRAM_OE_n, CRAM_ADV_n, CRAM_UB_n, CRAM_LB_n},
                {1'b1, 1'b0, CRAM_CE_n, CRAM_CE_n});
            if (InFIFO_Rd) chk("rd_while_empty", InFIFO_Empty, 0);
            if (!CRAM_WE_n) begin
                if (wlen == 0) begin
                    ca = CRAM_A;
                    cd = CRAM_DQ_Out;
                end
                chk("we_pulse_bus", {CRAM_CE_n, CRAM_DQ_OE, CRAM_A, CRAM_DQ_Out}, {1'b0, 1'b1, ca, cd});
                wlen++;
            end else if (wlen != 0) begin
                chk("data_hold", {CRAM_CE_n, CRAM_DQ_OE, CRAM_DQ_Out}, {1'b1, 1'b1, cd});
                chk("we_len", wlen, T_WP);
                chk("write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", ca, e.a);
                    chk("wr_data", cd, e.d);
                end
                wlen = 0;
            end
            if (Done) begin
                chk("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) chk("aborted", Aborted, exp_done.pop_front());
            end
        end
    end

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ctl"}, {Busy, Done, Aborted, InFIFO_Rd, CRAM_DQ_OE}, 0);
        chk({nm, "_bus"}, {CRAM_A, CRAM_DQ_Out}, 0);
        chk({nm, "_pins"}, {CRAM_CE_n, CRAM_WE_n, CRAM_OE_n, CRAM_UB_n, CRAM_LB_n, CRAM_ADV_n}, 6'b111110);
    endtask

    task automatic start_xfer(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
        @(negedge Clock);
        Start = 1'b1; StartAddr = a; NumHWords = n;
        @(negedge Clock);
        Start = 1'b0;
        chk("busy_after_start", Busy, 1);
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!Done && cyc < budget) begin
            @(negedge Clock);
            cyc++;
        end
        chk("done_seen", Done, 1);
        @(negedge Clock);
        chk("done_one_cycle", {Done, Busy}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, base, cnt, guard, low, pulses;
        logic ok;
        aReset_n = 1'b0; Start = 1'b0; StartAddr = '0; NumHWords = '0; Abort = 1'b0;
        force_empty = 1'b0; InFIFO_Empty = 1'b1; InFIFO_Data = '0;
        repeat (3) @(negedge Clock);
        chk_reset_vals("por");
        aReset_n = 1'b1;

        // Reset in the 5th WE# low cycle: no write completes, no Done.
        fifo_q = '{16'h1111, 16'h2222};
        start_xfer(23'h000050, 8'd2);
        cnt = 0; guard = 0;
        while (cnt < 5 && guard < 100) begin
            @(negedge Clock);
            guard++;
            if (!CRAM_WE_n) cnt++;
        end
        chk("reached_we5", cnt, 5);
        #2 aReset_n = 1'b0;
        #1 chk_reset_vals("midrst");
        fifo_q.delete();
        @(negedge Clock);
        @(negedge Clock);
        aReset_n = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge Clock);
            if (Done || Busy || !CRAM_CE_n) ok = 1'b0;
        end
        chk("idle_after_rst", ok, 1);

        // Normal 3-word burst.
        fifo_q = '{16'hAAAA, 16'h5555, 16'h1234};
        exp_wr.push_back('{23'h000100, 16'hAAAA});
        exp_wr.push_back('{23'h000101, 16'h5555});
        exp_wr.push_back('{23'h000102, 16'h1234});
        exp_done.push_back(1'b0);
        base = pops;
        start_xfer(23'h000100, 8'd3);
        wait_done(100, cyc);
        chk("burst3_cycles", cyc, 33);
        chk("burst3_pops", pops - base, 3);

        // FIFO stall.
        force_empty = 1'b1;
        fifo_q = '{16'hBEEF};
        exp_wr.push_back('{23'h000200, 16'hBEEF});
        exp_done.push_back(1'b0);
        base = pops;
        start_xfer(23'h000200, 8'd1);
        ok = 1'b1;
        repeat (20) begin
            @(negedge Clock);
            if (!CRAM_CE_n || InFIFO_Rd) ok = 1'b0;
        end
        chk("stall_quiet", ok, 1);
        force_empty = 1'b0;
        wait_done(40, cyc);
        chk("stall_pops", pops - base, 1);

        // Address wrap.
        fifo_q = '{16'h0F0F, 16'hF0F0};
        exp_wr.push_back('{23'h7FFFFF, 16'h0F0F});
        exp_wr.push_back('{23'h000000, 16'hF0F0});
        exp_done.push_back(1'b0);
        base = pops;
        start_xfer(23'h7FFFFF, 8'd2);
        wait_done(60, cyc);
        chk("wrap_pops", pops - base, 2);

        // Zero-length request.
        fifo_q = '{16'h7777};
        exp_done.push_back(1'b0);
        base = pops;
        start_xfer(23'h000400, 8'd0);
        wait_done(10, cyc);
        chk("zero_len_quick", cyc <= 2, 1);
        chk("zero_len_pops", pops - base, 0);
        fifo_q.delete();
        repeat (3) @(negedge Clock);

        // Abort on the 3rd WRITE cycle of word 2 of 4.
        fifo_q = '{16'h1001, 16'h1002, 16'h1003, 16'h1004};
        exp_wr.push_back('{23'h000300, 16'h1001});
        exp_wr.push_back('{23'h000301, 16'h1002});
        exp_done.push_back(1'b1);
        base = pops;
        start_xfer(23'h000300, 8'd4);
        low = 0; pulses = 0; guard = 0;
        while (!(pulses == 1 && low == 3) && guard < 200) begin
            @(negedge Clock);
            guard++;
            if (!CRAM_WE_n) low++;
            else if (low != 0) begin
                pulses++;
                low = 0;
            end
        end
        chk("abort_point", {pulses[7:0], low[7:0]}, 16'h0103);
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        wait_done(40, cyc);
        chk("abort_pops", pops - base, 2);
        fifo_q.delete();

        repeat (5) @(negedge Clock);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
